cpi_a2f_req_ingress: RTL and testbench

- Downstream consumer of the fabric manager's CPI A2F request layer.
- Once the connect handshake completes, it accepts agent request flits (protocol_id plus 128-bit header) into a credit-managed FIFO.
- It returns one credit per freed slot to the agent, and presents queued requests to the fabric core over a valid/ready interface.
- When the link drops, it drains the queue in order before returning to idle.

---
 rtl/cpi_a2f_req_ingress.sv | 191 +++++++++++++++++++
 tb/tb_cpi_a2f_req_ingress.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpi_a2f_req_ingress.sv
// cpi_a2f_req_ingress
// Receives CPI A2F request flits from the agent once the link is connected.
// Accepted flits go into a credit-managed FIFO that feeds the fabric core over
// valid/ready. One credit is returned to the agent for every freed slot.
// When the link drops, the queue is drained in order before returning to idle.
module cpi_a2f_req_ingress #(
    parameter int                      DEPTH    = 8,
    parameter int                      PID_W    = 4,
    parameter int                      HDR_W    = 128,
    parameter logic [(2**PID_W)-1:0]   PID_MASK = 16'h000F,
    localparam int                     CW       = $clog2(DEPTH + 1)
) (
    input  logic              fm_clk,
    input  logic              fm_rst,
    input  logic              link_up,
    input  logic              a2f_req_is_valid,
    input  logic [PID_W-1:0]  a2f_req_protocol_id,
    input  logic [HDR_W-1:0]  a2f_req_header,
    output logic              a2f_req_rxcrd_valid,
    output logic              fab_req_valid,
    input  logic              fab_req_ready,
    output logic [PID_W-1:0]  fab_req_protocol_id,
    output logic [HDR_W-1:0]  fab_req_header,
    output logic [CW-1:0]     q_count,
    output logic              q_empty,
    output logic              ovf_err,
    output logic              pid_err
);

    localparam int            AW      = $clog2(DEPTH);
    localparam int            EW      = PID_W + HDR_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wrptr_q, wrptr_d;
    logic [AW-1:0]   rdptr_q, rdptr_d;
    logic [CW-1:0]   q_count_q, q_count_d;
    logic [CW-1:0]   crd_pend_q, crd_pend_d;
    logic            rxcrd_q, rxcrd_d;
    logic            ovf_err_q, ovf_err_d;
    logic            pid_err_q, pid_err_d;

    logic [EW-1:0]   mem_q [DEPTH];

    logic            flit_s;
    logic            pid_ok_s;
    logic            full_s;
    logic            pop_s;
    logic            push_ok_s;
    logic            pid_drop_s;
    logic            ovf_drop_s;
    logic            crd_dec_s;
    logic [EW-1:0]   head_s;

    // Classify this cycle's flit and head handshake.
    always_comb begin
        flit_s     = (state_q == ST_ACTIVE) && a2f_req_is_valid;
        pid_ok_s   = PID_MASK[a2f_req_protocol_id];
        full_s     = (q_count_q == DEPTH_C);
        pop_s      = (q_count_q != {CW{1'b0}}) && fab_req_ready;
        // A full queue still accepts a push when the head leaves in the same cycle.
        push_ok_s  = flit_s && pid_ok_s && (!full_s || pop_s);
        pid_drop_s = flit_s && !pid_ok_s;
        ovf_drop_s = flit_s && pid_ok_s && full_s && !pop_s;
    end

    // Pointer, occupancy and sticky error next-state.
    always_comb begin
        wrptr_d   = wrptr_q;
        rdptr_d   = rdptr_q;
        q_count_d = q_count_q;
        if (push_ok_s) begin
            wrptr_d = wrptr_q + AW'(1);
        end else begin
            wrptr_d = wrptr_q;
        end
        if (pop_s) begin
            rdptr_d = rdptr_q + AW'(1);
        end else begin
            rdptr_d = rdptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   q_count_d = q_count_q + CW'(1);
            2'b01:   q_count_d = q_count_q - CW'(1);
            default: q_count_d = q_count_q;
        endcase
        ovf_err_d = ovf_err_q | ovf_drop_s;
        pid_err_d = pid_err_q | pid_drop_s;
    end

    // Connection state and credit bookkeeping next-state.
    always_comb begin
        state_d    = state_q;
        crd_pend_d = crd_pend_q;
        rxcrd_d    = 1'b0;
        crd_dec_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (link_up) begin
                    state_d    = ST_ACTIVE;
                    crd_pend_d = DEPTH_C;
                end else begin
                    state_d    = ST_IDLE;
                    crd_pend_d = {CW{1'b0}};
                end
            end
            ST_ACTIVE: begin
                if (!link_up) begin
                    // Credits still owed are forfeited; the agent reconnects with a fresh grant.
                    state_d    = ST_DRAIN;
                    crd_pend_d = {CW{1'b0}};
                end else begin
                    state_d    = ST_ACTIVE;
                    crd_dec_s  = (crd_pend_q != {CW{1'b0}});
                    rxcrd_d    = crd_dec_s;
                    // Illegal-pid drops still consumed an agent credit, so it goes back.
                    crd_pend_d = crd_pend_q + CW'(pid_drop_s) + CW'(pop_s) - CW'(crd_dec_s);
                end
            end
            ST_DRAIN: begin
                crd_pend_d = {CW{1'b0}};
                if (q_count_q == {CW{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                crd_pend_d = {CW{1'b0}};
            end
        endcase
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge fm_clk or negedge fm_rst) begin
        if (!fm_rst) begin
            state_q    <= ST_IDLE;
            wrptr_q    <= {AW{1'b0}};
            rdptr_q    <= {AW{1'b0}};
            q_count_q  <= {CW{1'b0}};
            crd_pend_q <= {CW{1'b0}};
            rxcrd_q    <= 1'b0;
            ovf_err_q  <= 1'b0;
            pid_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrptr_q    <= wrptr_d;
            rdptr_q    <= rdptr_d;
            q_count_q  <= q_count_d;
            crd_pend_q <= crd_pend_d;
            rxcrd_q    <= rxcrd_d;
            ovf_err_q  <= ovf_err_d;
            pid_err_q  <= pid_err_d;
        end
    end

    // Queue storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge fm_clk) begin
        if (push_ok_s) begin
            mem_q[wrptr_q] <= {a2f_req_protocol_id, a2f_req_header};
        end
    end

    // Head presentation: entry at the read pointer, forced to zero when empty.
    always_comb begin
        head_s = mem_q[rdptr_q];
        if (q_count_q != {CW{1'b0}}) begin
            fab_req_valid       = 1'b1;
            fab_req_protocol_id = head_s[EW-1:HDR_W];
            fab_req_header      = head_s[HDR_W-1:0];
        end else begin
            fab_req_valid       = 1'b0;
            fab_req_protocol_id = {PID_W{1'b0}};
            fab_req_header      = {HDR_W{1'b0}};
        end
    end

    assign a2f_req_rxcrd_valid = rxcrd_q;
    assign q_count             = q_count_q;
    assign q_empty             = (q_count_q == {CW{1'b0}}) && (crd_pend_q == {CW{1'b0}});
    assign ovf_err             = ovf_err_q;
    assign pid_err             = pid_err_q;

endmodule

// File: tb/tb_cpi_a2f_req_ingress.sv
// Directed bench for cpi_a2f_req_ingress: link-up credit grant, ordered flow,
// full/overflow/wrap, illegal pid, link drop with drain, async reset.
module tb_cpi_a2f_req_ingress;

    logic          fm_clk;
    logic          fm_rst;
    logic          link_up;
    logic          a2f_req_is_valid;
    logic [3:0]    a2f_req_protocol_id;
    logic [127:0]  a2f_req_header;
    logic          a2f_req_rxcrd_valid;
    logic          fab_req_valid;
    logic          fab_req_ready;
    logic [3:0]    fab_req_protocol_id;
    logic [127:0]  fab_req_header;
    logic [3:0]    q_count;
    logic          q_empty;
    logic          ovf_err;
    logic          pid_err;

    int n_checks;
    int n_errors;
    int pulse_cnt;

    cpi_a2f_req_ingress dut (
        .fm_clk              (fm_clk),
        .fm_rst              (fm_rst),
        .link_up             (link_up),
        .a2f_req_is_valid    (a2f_req_is_valid),
        .a2f_req_protocol_id (a2f_req_protocol_id),
        .a2f_req_header      (a2f_req_header),
        .a2f_req_rxcrd_valid (a2f_req_rxcrd_valid),
        .fab_req_valid       (fab_req_valid),
        .fab_req_ready       (fab_req_ready),
        .fab_req_protocol_id (fab_req_protocol_id),
        .fab_req_header      (fab_req_header),
        .q_count             (q_count),
        .q_empty             (q_empty),
        .ovf_err             (ovf_err),
        .pid_err             (pid_err)
    );

    // 100 MHz clock.
    initial begin
        fm_clk = 1'b0;
        forever #5 fm_clk = ~fm_clk;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 ns after the edge, tally credit pulses.
    task automatic tick();
        @(posedge fm_clk);
        #1;
        if (a2f_req_rxcrd_valid === 1'b1) pulse_cnt = pulse_cnt + 1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        pulse_cnt = 0;
        fm_rst = 1'b0;
        link_up = 1'b0;
        a2f_req_is_valid = 1'b0;
        a2f_req_protocol_id = 4'd0;
        a2f_req_header = 128'd0;
        fab_req_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_rxcrd", a2f_req_rxcrd_valid, 1'b0);
        check("rst_valid", fab_req_valid, 1'b0);
        check("rst_qcount", q_count, 4'd0);
        check("rst_qempty", q_empty, 1'b1);
        check("rst_ovf", ovf_err, 1'b0);
        check("rst_pid", pid_err, 1'b0);
        check("rst_hdr", fab_req_header, 128'd0);

        // Link-up credit grant: 8 back-to-back pulses
        fm_rst = 1'b1;
        tick();
        check("idle_qempty", q_empty, 1'b1);
        link_up = 1'b1;
        tick();
        check("grant_qempty_fall", q_empty, 1'b0);
        check("grant_no_pulse_yet", a2f_req_rxcrd_valid, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("grant_pulse%0d", i), a2f_req_rxcrd_valid, 1'b1);
        end
        check("grant_qempty_rise", q_empty, 1'b1);
        tick();
        check("grant_train_end", a2f_req_rxcrd_valid, 1'b0);

        // Ordered flow with ready high
        pulse_cnt = 0;
        fab_req_ready = 1'b1;
        a2f_req_is_valid = 1'b1;
        a2f_req_protocol_id = 4'd1;
        a2f_req_header = 128'hA0;
        tick();
        check("flow_valid", fab_req_valid, 1'b1);
        check("flow_hdr0", fab_req_header, 128'hA0);
        check("flow_pid0", fab_req_protocol_id, 4'd1);
        check("flow_cnt0", q_count, 4'd1);
        a2f_req_header = 128'hA1;
        tick();
        check("flow_hdr1", fab_req_header, 128'hA1);
        check("flow_latency", a2f_req_rxcrd_valid, 1'b0);
        a2f_req_header = 128'hA2;
        tick();
        check("flow_hdr2", fab_req_header, 128'hA2);
        a2f_req_is_valid = 1'b0;
        tick();
        check("flow_empty", fab_req_valid, 1'b0);
        check("flow_cnt_end", q_count, 4'd0);
        tick();
        tick();
        tick();
        check("flow_pulses", pulse_cnt, 3);

        // Full, overflow, wrap with concurrent push/pop
        pulse_cnt = 0;
        fab_req_ready = 1'b0;
        a2f_req_is_valid = 1'b1;
        a2f_req_protocol_id = 4'd2;
        for (int i = 0; i < 8; i++) begin
            a2f_req_header = 128'hB0 + 128'(i);
            tick();
        end
        check("full_cnt", q_count, 4'd8);
        check("full_head", fab_req_header, 128'hB0);
        check("full_pid", fab_req_protocol_id, 4'd2);
        check("full_no_ovf", ovf_err, 1'b0);
        a2f_req_header = 128'hBF;
        tick();
        check("ovf_flag", ovf_err, 1'b1);
        check("ovf_cnt", q_count, 4'd8);
        check("ovf_head", fab_req_header, 128'hB0);
        fab_req_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("wrap_head%0d", i), fab_req_header,
                  (i < 8) ? (128'hB0 + 128'(i)) : (128'hC0 + 128'(i - 8)));
            a2f_req_header = 128'hC0 + 128'(i);
            tick();
            check($sformatf("wrap_cnt%0d", i), q_count, 4'd8);
        end
        a2f_req_is_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wrap_tail%0d", i), fab_req_header, 128'hC4 + 128'(i));
            tick();
        end
        check("wrap_drained", q_count, 4'd0);
        for (int i = 0; i < 4; i++) tick();
        check("wrap_pulses", pulse_cnt, 20);
        check("wrap_qempty", q_empty, 1'b1);
        check("wrap_no_piderr", pid_err, 1'b0);

        // Illegal protocol id
        pulse_cnt = 0;
        fab_req_ready = 1'b0;
        a2f_req_is_valid = 1'b1;
        a2f_req_protocol_id = 4'd5;
        a2f_req_header = 128'hDD;
        tick();
        a2f_req_is_valid = 1'b0;
        check("pid_flag", pid_err, 1'b1);
        check("pid_cnt", q_count, 4'd0);
        check("pid_novalid", fab_req_valid, 1'b0);
        tick();
        tick();
        tick();
        check("pid_pulse", pulse_cnt, 1);

        // Link drop with queued entries
        a2f_req_is_valid = 1'b1;
        a2f_req_protocol_id = 4'd3;
        for (int i = 0; i < 6; i++) begin
            a2f_req_header = 128'h60 + 128'(i);
            tick();
        end
        a2f_req_is_valid = 1'b0;
        fab_req_ready = 1'b1;
        tick();
        check("drop_pre_cnt", q_count, 4'd5);
        fab_req_ready = 1'b0;
        link_up = 1'b0;
        pulse_cnt = 0;
        tick();
        check("drop_no_pulse", a2f_req_rxcrd_valid, 1'b0);
        check("drop_cnt", q_count, 4'd5);
        a2f_req_is_valid = 1'b1;
        a2f_req_protocol_id = 4'd1;
        a2f_req_header = 128'hFF;
        tick();
        a2f_req_is_valid = 1'b0;
        check("drain_push_ignored", q_count, 4'd5);
        fab_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drain_hdr%0d", i), fab_req_header, 128'h61 + 128'(i));
            tick();
        end
        check("drain_empty", fab_req_valid, 1'b0);
        tick();
        check("drain_no_credits", pulse_cnt, 0);
        check("drain_qempty", q_empty, 1'b1);
        link_up = 1'b1;
        pulse_cnt = 0;
        for (int i = 0; i < 12; i++) tick();
        check("relink_pulses", pulse_cnt, 8);

        // Async reset mid-drain
        fab_req_ready = 1'b0;
        a2f_req_is_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a2f_req_header = 128'h70 + 128'(i);
            tick();
        end
        a2f_req_is_valid = 1'b0;
        fab_req_ready = 1'b1;
        tick();
        fab_req_ready = 1'b0;
        link_up = 1'b0;
        tick();
        check("ar_pre_cnt", q_count, 4'd3);
        check("ar_pre_valid", fab_req_valid, 1'b1);
        #2;
        fm_rst = 1'b0;
        #1;
        check("ar_valid", fab_req_valid, 1'b0);
        check("ar_cnt", q_count, 4'd0);
        check("ar_qempty", q_empty, 1'b1);
        check("ar_rxcrd", a2f_req_rxcrd_valid, 1'b0);
        check("ar_hdr", fab_req_header, 128'd0);
        check("ar_ovf", ovf_err, 1'b0);
        check("ar_pid", pid_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
